instr_fetch_ctrl: RTL and testbench
===================================

Name: instr_fetch_ctrl

Overview:
- Fetch-side controller that feeds the instruction register: holds the program counter, reads 16-bit instruction words from instruction memory over a req/ack handshake, presents `ins`, and pulses `IL` so the instruction register latches opcode/DR/SA/SB.
- Sequences fetch → load → execute-wait.
- Applies a branch target or PC+1 after each instruction.
- Supports halt and resume.

Parameters:
- PC_W, 8, program counter / memory address width in bits.
- RESET_PC, 0, PC value loaded on reset (PC_W bits).

Ports:
- clk_main  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin or resume fetching; sampled in IDLE and HALT only
- halt_req  in  1  request to stop after the current instruction completes
- exec_done  in  1  datapath finished executing the current instruction
- branch  in  1  qualifies exec_done; take branch_addr as next PC
- branch_addr  in  PC_W  branch target
- mem_rdata  in  16  instruction memory read data, valid when mem_ack=1
- mem_ack  in  1  memory read acknowledge, one or more cycles after mem_req
- mem_req  out  1  memory read request
- mem_addr  out  PC_W  memory read address
- ins  out  16  fetched instruction word, to instruction register
- IL  out  1  instruction load strobe, to instruction register
- pc  out  PC_W  current program counter
- busy  out  1  FSM not in IDLE or HALT
- halted  out  1  FSM in HALT

Behaviour:
- Reset (async, immediate, any state):
  - state=IDLE, pc=RESET_PC, ins=0, IL=0, mem_req=0, halt_pending=0.
  - mem_addr=RESET_PC, busy=0, halted=0.
  - All outputs are registered or decoded from registered state; no combinational input-to-output paths.
- States: IDLE, FETCH, LOAD, EXEC, HALT.
- IDLE:
  - start=1 → FETCH.
  - All other inputs ignored.
- FETCH:
  - mem_req=1 and mem_addr=pc, held stable until ack.
  - On the edge where mem_ack=1: ins<=mem_rdata, → LOAD.
  - mem_ack=0: stay; any number of wait cycles allowed.
- LOAD (exactly 1 cycle):
  - IL=1, ins stable; the instruction register captures on this cycle's closing edge.
  - pc<=pc+1 modulo 2^PC_W (wraps from all-ones to 0).
  - → EXEC.
- EXEC:
  - IL=0, mem_req=0, ins held.
  - Wait for exec_done=1. On that edge:
    - if branch=1, pc<=branch_addr (overrides the increment done in LOAD);
    - if halt_pending or halt_req → HALT and clear halt_pending; else → FETCH.
  - branch is ignored when exec_done=0.
- halt_req:
  - Asserted in FETCH/LOAD/EXEC sets sticky halt_pending.
  - The current instruction always completes; no abort.
  - Ignored in IDLE.
- HALT:
  - halted=1, busy=0, pc and ins held.
  - start=1 → FETCH at current pc.
  - halt_req and exec_done ignored.
- Handshake rules:
  - mem_ack outside FETCH is ignored.
  - mem_req deasserts on the cycle after ack is sampled.
  - Minimum fetch-to-next-fetch: FETCH(1, zero-wait ack) + LOAD(1) + EXEC(≥1) = 3 cycles.
- IL:
  - High for exactly one cycle per fetched instruction.
  - Never high in IDLE/HALT/FETCH/EXEC.
- Reset mid-operation:
  - In-flight fetch is abandoned; mem_req drops asynchronously.
  - A late mem_ack after reset is ignored (FSM is in IDLE).

Test Plan:
- Reset then idle: assert reset mid-sim → pc=0, IL=0, mem_req=0, busy=0; 10 cycles with no start → no mem_req.
- Sequential fetch:
  - Memory [0]=16'h1234, [1]=16'h5678, [2]=16'h9ABC, zero-wait ack; start, exec_done one cycle after each IL.
  - → mem_addr 0,1,2 in order; IL pulses with ins=1234, 5678, 9ABC; pc=3 after the third; each IL exactly 1 cycle wide.
- Wait states: mem_ack delayed 4 cycles → mem_req and mem_addr stable for 5 cycles, single IL, correct ins.
- Branch: at pc=5, exec_done=1 with branch=1 and branch_addr=8'h40 → next mem_addr=8'h40; without branch the next mem_addr is 6.
- Halt and wrap:
  - PC_W=8, start at pc=8'hFF; halt_req pulsed during FETCH.
  - → instruction at FF fetched and executed, pc wraps to 00, HALT entered (halted=1, no further mem_req).
  - start → fetch at 00.
- Async reset mid-fetch: reset asserted while mem_req=1 and before ack → mem_req=0 immediately (no clock edge); ack arriving after reset release → no IL, state IDLE.

Source files
------------

// File: rtl/instr_fetch_ctrl_if.sv
// Instruction-memory read bus between the fetch controller and the memory.
//   mem_req   : read request, held until acknowledged (master -> slave)
//   mem_addr  : read address, PC_W bits (master -> slave)
//   mem_rdata : 16-bit instruction word, valid while mem_ack=1 (slave -> master)
//   mem_ack   : read acknowledge (slave -> master)
interface instr_fetch_ctrl_if #(
  parameter int unsigned PC_W = 8
);
  logic            mem_req;
  logic [PC_W-1:0] mem_addr;
  logic [15:0]     mem_rdata;
  logic            mem_ack;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Fetch-side controller feeding the instruction register.
// Holds the program counter, reads instruction words over the mem bus
// req/ack handshake, presents them on ins and pulses IL for one cycle so
// the instruction register latches them, then waits for the datapath to
// finish before fetching the next word (PC+1 or branch target). Supports
// a sticky halt request and resume via start.
// Ports:
//   clk_main    : rising-edge clock
//   reset       : asynchronous active-high reset
//   start       : begin/resume fetching (looked at in IDLE and HALT only)
//   halt_req    : stop after the current instruction completes
//   exec_done   : datapath finished the current instruction
//   branch      : with exec_done, load branch_addr as next PC
//   branch_addr : branch target
//   mem         : instruction-memory bus (master side)
//   ins         : fetched instruction word
//   IL          : instruction load strobe
//   pc          : current program counter
//   busy        : fetching, loading or executing
//   halted      : stopped in HALT
module instr_fetch_ctrl #(
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                clk_main,
  input  logic                reset,
  input  logic                start,
  input  logic                halt_req,
  input  logic                exec_done,
  input  logic                branch,
  input  logic [PC_W-1:0]     branch_addr,
  instr_fetch_ctrl_if.master  mem,
  output logic [15:0]         ins,
  output logic                IL,
  output logic [PC_W-1:0]     pc,
  output logic                busy,
  output logic                halted
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_EXEC  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ins_q, ins_d;
  logic            halt_pending_q, halt_pending_d;
  logic            in_instr;
  logic            stop_after;

  // A halt request counts while an instruction is in flight; a request
  // arriving on the same edge as exec_done still halts.
  assign in_instr   = (state_q == S_FETCH) || (state_q == S_LOAD) || (state_q == S_EXEC);
  assign stop_after = halt_pending_q || halt_req;

  // State register (all flops; asynchronous reset)
  always_ff @(posedge clk_main or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      pc_q           <= RESET_PC;
      ins_q          <= '0;
      halt_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      ins_q          <= ins_d;
      halt_pending_q <= halt_pending_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_FETCH;
      S_FETCH: if (mem.mem_ack) state_d = S_LOAD;
      S_LOAD:  state_d = S_EXEC;
      S_EXEC:  if (exec_done) state_d = stop_after ? S_HALT : S_FETCH;
      S_HALT:  if (start) state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    pc_d           = pc_q;
    ins_d          = ins_q;
    halt_pending_d = halt_pending_q;

    if (state_q == S_FETCH && mem.mem_ack) begin
      ins_d = mem.mem_rdata;
    end

    // PC advances during LOAD so EXEC already sees PC+1; a taken branch
    // at the end of EXEC simply overwrites it.
    if (state_q == S_LOAD) begin
      pc_d = pc_q + PC_W'(1);
    end
    if (state_q == S_EXEC && exec_done && branch) begin
      pc_d = branch_addr;
    end

    if (in_instr && halt_req) begin
      halt_pending_d = 1'b1;
    end
    // Instruction retires here; the pending request is consumed either way.
    if (state_q == S_EXEC && exec_done) begin
      halt_pending_d = 1'b0;
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    mem.mem_req = (state_q == S_FETCH);
    IL          = (state_q == S_LOAD);
    busy        = in_instr;
    halted      = (state_q == S_HALT);
  end

  assign mem.mem_addr = pc_q;
  assign pc           = pc_q;
  assign ins          = ins_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
module tb_instr_fetch_ctrl;

  logic        clk_main = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        halt_req = 1'b0;
  logic        exec_done = 1'b0;
  logic        branch = 1'b0;
  logic [7:0]  branch_addr = 8'h00;
  logic [15:0] ins;
  logic        IL;
  logic [7:0]  pc;
  logic        busy;
  logic        halted;

  instr_fetch_ctrl_if #(.PC_W(8)) mem_bus ();

  instr_fetch_ctrl #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk_main    (clk_main),
    .reset       (reset),
    .start       (start),
    .halt_req    (halt_req),
    .exec_done   (exec_done),
    .branch      (branch),
    .branch_addr (branch_addr),
    .mem         (mem_bus),
    .ins         (ins),
    .IL          (IL),
    .pc          (pc),
    .busy        (busy),
    .halted      (halted)
  );

  always #5 clk_main = ~clk_main;

  // ---------------- counters and checker ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model state ----------------
  typedef struct {
    logic [7:0]  addr;
    logic [15:0] word;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] mem_arr [256];
  logic [7:0]  model_pc = 8'h00;
  bit          pending = 1'b0;
  bit          is_halted = 1'b0;

  // ---------------- memory responder ----------------
  int          fixed_wait = 0;    // <0 selects a random wait per fetch
  bit          force_ack = 1'b0;
  int          cur_wait = 0;
  int          wait_left = 0;
  int          req_cycles = 0;
  logic [7:0]  req_addr = 8'h00;

  initial begin
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = 16'h0000;
  end

  always @(negedge clk_main) begin
    if (reset) begin
      mem_bus.mem_ack = 1'b0;
      req_cycles      = 0;
    end else if (force_ack) begin
      mem_bus.mem_ack   = 1'b1;
      mem_bus.mem_rdata = 16'hDEAD;
    end else if (mem_bus.mem_req) begin
      if (req_cycles == 0) begin
        req_addr  = mem_bus.mem_addr;
        cur_wait  = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
        wait_left = cur_wait;
      end else begin
        chk("req_addr_stable", 32'(mem_bus.mem_addr), 32'(req_addr));
      end
      req_cycles++;
      if (wait_left == 0) begin
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = mem_arr[mem_bus.mem_addr];
      end else begin
        wait_left--;
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = 16'($urandom);
      end
    end else begin
      if (req_cycles != 0) begin
        chk("req_len", 32'(req_cycles), 32'(cur_wait + 1));
        req_cycles = 0;
      end
      // Stray acks outside a fetch must be ignored.
      mem_bus.mem_ack   = ($urandom_range(0, 3) == 0);
      mem_bus.mem_rdata = 16'($urandom);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [15:0] last_ins = 16'h0000;
  bit          il_prev = 1'b0;

  always @(negedge clk_main) begin
    if (reset) begin
      last_ins = 16'h0000;
      il_prev  = 1'b0;
    end else begin
      if (IL) begin
        exp_t e;
        chk("il_width", 32'(il_prev), 32'd0);
        chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          $display("fetch pc=%02h ins=%04h (expect pc=%02h ins=%04h)", pc, ins, e.addr, e.word);
          chk("il_pc", 32'(pc), 32'(e.addr));
          chk("il_ins", 32'(ins), 32'(e.word));
        end
        last_ins = ins;
      end else begin
        chk("ins_hold", 32'(ins), 32'(last_ins));
      end
      il_prev = IL;
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic wait_il(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_main);
      halt_req = 1'b0;
      if (IL) begin
        ok = 1'b1;
        break;
      end
    end
    chk("il_timeout", 32'(ok), 32'd1);
  endtask

  task automatic do_start(input bit hf);
    halt_req  = 1'b0;
    exec_done = 1'b0;
    branch    = 1'b0;
    start     = 1'b1;
    @(negedge clk_main);
    start = 1'b0;
    is_halted = 1'b0;
    exp_q.push_back('{addr: model_pc, word: mem_arr[model_pc]});
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_req", 32'(mem_bus.mem_req), 32'd1);
    if (hf) begin
      halt_req = 1'b1;   // during FETCH
      pending  = 1'b1;
    end
  endtask

  // hmode: 0 none, 1 pulse in EXEC, 2 with exec_done, 3 pulse in LOAD
  task automatic run_instr(input bit br, input logic [7:0] baddr, input int hmode,
                           input int ew, input bit halt_next_fetch);
    bit ok;
    bit will_halt;
    wait_il(ok);
    if (!ok) return;
    if (hmode == 3) halt_req = 1'b1;
    model_pc = model_pc + 8'd1;
    @(negedge clk_main);
    halt_req = 1'b0;
    chk("pc_after_load", 32'(pc), 32'(model_pc));
    chk("exec_req", 32'(mem_bus.mem_req), 32'd0);
    for (int i = 0; i < ew; i++) begin
      branch      = $urandom_range(0, 1) == 1;   // ignored without exec_done
      branch_addr = 8'($urandom);
      halt_req    = (hmode == 1) && (i == 0);
      @(negedge clk_main);
    end
    halt_req    = (hmode == 2) || (hmode == 1 && ew == 0);
    exec_done   = 1'b1;
    branch      = br;
    branch_addr = baddr;
    will_halt   = pending || (hmode != 0);
    if (br) model_pc = baddr;
    @(negedge clk_main);
    exec_done = 1'b0;
    branch    = 1'b0;
    halt_req  = 1'b0;
    pending   = 1'b0;
    chk("next_pc", 32'(pc), 32'(model_pc));
    if (will_halt) begin
      is_halted = 1'b1;
      chk("halted", 32'(halted), 32'd1);
      chk("halt_busy", 32'(busy), 32'd0);
      chk("halt_req_low", 32'(mem_bus.mem_req), 32'd0);
    end else begin
      exp_q.push_back('{addr: model_pc, word: mem_arr[model_pc]});
      chk("refetch_busy", 32'(busy), 32'd1);
      if (halt_next_fetch) begin
        halt_req = 1'b1;
        pending  = 1'b1;
      end
    end
  endtask

  // Sit in HALT with noise on inputs that HALT must ignore.
  task automatic halt_idle(input int n);
    for (int i = 0; i < n; i++) begin
      exec_done   = $urandom_range(0, 1) == 1;
      halt_req    = $urandom_range(0, 1) == 1;
      branch      = $urandom_range(0, 1) == 1;
      branch_addr = 8'($urandom);
      @(negedge clk_main);
      chk("hold_halted", 32'(halted), 32'd1);
      chk("hold_no_req", 32'(mem_bus.mem_req), 32'd0);
      chk("hold_pc", 32'(pc), 32'(model_pc));
    end
    exec_done = 1'b0;
    halt_req  = 1'b0;
    branch    = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit         r_br;
    logic [7:0] r_ba;
    int         r_hm;
    int         r_ew;
    bit         r_hf;

    for (int i = 0; i < 256; i++) mem_arr[i] = 16'($urandom);
    mem_arr[0] = 16'h1234;
    mem_arr[1] = 16'h5678;
    mem_arr[2] = 16'h9ABC;

    reset = 1'b1;
    repeat (2) @(negedge clk_main);
    chk("rst_pc", 32'(pc), 32'h00);
    chk("rst_addr", 32'(mem_bus.mem_addr), 32'h00);
    chk("rst_il", 32'(IL), 32'd0);
    chk("rst_req", 32'(mem_bus.mem_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_ins", 32'(ins), 32'h0000);
    #2 reset = 1'b0;

    // Idle: no start, halt_req noise is ignored
    for (int i = 0; i < 10; i++) begin
      halt_req = $urandom_range(0, 1) == 1;
      @(negedge clk_main);
      chk("idle_req", 32'(mem_bus.mem_req), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
    end
    halt_req = 1'b0;

    // Sequential zero-wait fetches of 0,1,2
    fixed_wait = 0;
    model_pc   = 8'h00;
    do_start(1'b0);
    run_instr(1'b0, 8'h00, 0, 0, 1'b0);
    run_instr(1'b0, 8'h00, 0, 0, 1'b0);
    #1 fixed_wait = 4;                  // applies to the fetch at pc=3
    run_instr(1'b0, 8'h00, 0, 0, 1'b0); // pc becomes 3
    #1 fixed_wait = -1;
    // Wait-state fetch at 3, then branch to 5
    run_instr(1'b1, 8'h05, 0, 1, 1'b0);
    // At pc=5 branch to 0x40, then back to 5 and fall through to 6
    run_instr(1'b1, 8'h40, 0, 0, 1'b0);
    run_instr(1'b1, 8'h05, 0, 2, 1'b0);
    run_instr(1'b0, 8'h00, 0, 0, 1'b0);
    // From 6 branch to FF with halt_req pulsed during the FETCH of FF
    run_instr(1'b1, 8'hFF, 0, 0, 1'b1);
    run_instr(1'b0, 8'h00, 0, 1, 1'b0);  // wraps to 00 and halts
    halt_idle(5);
    do_start(1'b0);                      // resume at 00
    run_instr(1'b0, 8'h00, 3, 0, 1'b0);  // halt requested in LOAD
    halt_idle(2);
    do_start(1'b0);

    // Randomised run
    for (int k = 0; k < 40; k++) begin
      r_br = $urandom_range(0, 2) == 0;
      r_ba = 8'($urandom);
      r_hm = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      r_ew = int'($urandom_range(0, 3));
      r_hf = $urandom_range(0, 9) == 0;
      run_instr(r_br, r_ba, r_hm, r_ew, r_hf);
      if (is_halted) begin
        halt_idle(int'($urandom_range(1, 4)));
        do_start($urandom_range(0, 5) == 0);
      end
    end
    if (!is_halted) run_instr(1'b0, 8'h00, 2, 0, 1'b0);

    // Asynchronous reset in the middle of a waiting fetch
    #1 fixed_wait = 6;
    do_start(1'b0);
    @(negedge clk_main);
    #2 reset = 1'b1;
    #1;
    chk("async_req", 32'(mem_bus.mem_req), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_pc", 32'(pc), 32'h00);
    chk("async_halted", 32'(halted), 32'd0);
    exp_q.delete();
    model_pc  = 8'h00;
    pending   = 1'b0;
    is_halted = 1'b0;
    @(negedge clk_main);
    #2 reset = 1'b0;
    force_ack = 1'b1;                    // late ack must be ignored
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_main);
      chk("late_ack_il", 32'(IL), 32'd0);
      chk("late_ack_busy", 32'(busy), 32'd0);
    end
    force_ack = 1'b0;
    #1 fixed_wait = -1;
    do_start(1'b0);
    run_instr(1'b0, 8'h00, 2, 1, 1'b0);
    repeat (2) @(negedge clk_main);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
